// File: rtl/var_assign_table.sv
// var_assign_table: variable assignment store and decision trail for the SAT datapath.
// Accepts decisions and implications, records each new assignment on a trail tagged
// with its decision level, flags conflicting implications and unwinds the trail on
// backtrack. Per-clause reads are combinational from the registered table.
// Optional build macro: VAT_STATS_EN enables the saturating implication/conflict counters;
// without it imp_count and conf_count are tied to zero.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | accepting backtrack / decision / implication (that priority)
// ST_UNWIND   | popping trail entries above the backtrack target level
// ST_CONFLICT | opposite-value implication seen; waiting for a backtrack
module var_assign_table #(
  parameter int NUM_VARIABLE         = 128,
  parameter int VARIABLE_INDEX       = 6,
  parameter int VAR_PER_CLAUSE       = 5,
  parameter int VAR_PER_CLAUSE_INDEX = VAR_PER_CLAUSE - 1
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          imp_valid,
  input  logic [VARIABLE_INDEX:0]                       imp_var,
  input  logic                                          imp_val,
  output logic                                          imp_ready,
  input  logic                                          dec_valid,
  input  logic [VARIABLE_INDEX:0]                       dec_var,
  input  logic                                          dec_val,
  input  logic                                          bt_valid,
  input  logic [VARIABLE_INDEX:0]                       bt_level,
  input  logic [VAR_PER_CLAUSE_INDEX:0][VARIABLE_INDEX:0] rd_var,
  output logic [VAR_PER_CLAUSE_INDEX:0]                 rd_unassign,
  output logic [VAR_PER_CLAUSE_INDEX:0]                 rd_val,
  output logic [VARIABLE_INDEX:0]                       level,
  output logic [VARIABLE_INDEX:0]                       trail_count,
  output logic                                          conflict,
  output logic                                          busy,
  output logic [15:0]                                   imp_count,
  output logic [15:0]                                   conf_count
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_UNWIND   = 2'd1;
  localparam logic [1:0] ST_CONFLICT = 2'd2;

  localparam logic [VARIABLE_INDEX:0] ID_ZERO = '0;
  localparam logic [VARIABLE_INDEX:0] ID_ONE  = {{VARIABLE_INDEX{1'b0}}, 1'b1};

  logic [1:0]               state_q;
  logic [VARIABLE_INDEX:0]  level_q;
  logic [VARIABLE_INDEX:0]  trail_count_q;
  logic [VARIABLE_INDEX:0]  bt_target_q;
  logic                     conflict_q;
  logic [NUM_VARIABLE-1:0]  assigned_q;
  logic [NUM_VARIABLE-1:0]  val_q;

  // Logical depth is NUM_VARIABLE-1 (ID 0 is never pushed); the extra slot keeps
  // the top-of-trail read index in range when the trail is empty.
  logic [VARIABLE_INDEX:0]  trail_var_mem [NUM_VARIABLE];
  logic [VARIABLE_INDEX:0]  trail_lvl_mem [NUM_VARIABLE];

  logic [VARIABLE_INDEX:0]  top_idx;
  logic [VARIABLE_INDEX:0]  top_var;
  logic [VARIABLE_INDEX:0]  top_lvl;
  logic                     bt_take;
  logic                     bt_unwind;
  logic                     dec_take;
  logic                     imp_hit;
  logic                     imp_write;
  logic                     imp_clash;
  logic                     pop_go;
  logic                     unwind_done;
  logic                     push_en;
  logic [VARIABLE_INDEX:0]  push_var;
  logic                     push_val;
  logic [VARIABLE_INDEX:0]  push_lvl;

  assign imp_ready   = (state_q == ST_IDLE) & ~bt_valid & ~dec_valid;
  assign level       = level_q;
  assign trail_count = trail_count_q;
  assign conflict    = conflict_q;
  assign busy        = (state_q == ST_UNWIND);

  // Decode this cycle's action from the request priority and the registered table.
  always_comb begin
    top_idx     = trail_count_q - ID_ONE;
    top_var     = trail_var_mem[top_idx];
    top_lvl     = trail_lvl_mem[top_idx];

    bt_take     = bt_valid & (state_q != ST_UNWIND);
    bt_unwind   = bt_take & (bt_level < level_q);

    dec_take    = (state_q == ST_IDLE) & ~bt_valid & dec_valid &
                  (dec_var != ID_ZERO) & ~assigned_q[dec_var];

    imp_hit     = imp_valid & imp_ready;
    imp_write   = imp_hit & (imp_var != ID_ZERO) & ~assigned_q[imp_var];
    imp_clash   = imp_hit & (imp_var != ID_ZERO) & assigned_q[imp_var] &
                  (val_q[imp_var] != imp_val);

    pop_go      = (state_q == ST_UNWIND) & (trail_count_q != ID_ZERO) &
                  (top_lvl > bt_target_q);
    unwind_done = (state_q == ST_UNWIND) & ~pop_go;

    push_en     = dec_take | imp_write;
    push_var    = dec_take ? dec_var : imp_var;
    push_val    = dec_take ? dec_val : imp_val;
    push_lvl    = dec_take ? (level_q + ID_ONE) : level_q;
  end

  // Control FSM: state, decision level, trail depth and the sticky conflict flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      level_q       <= '0;
      trail_count_q <= '0;
      bt_target_q   <= '0;
      conflict_q    <= 1'b0;
    end else begin
      if (bt_take) begin
        conflict_q  <= 1'b0;
        bt_target_q <= bt_level;
        state_q     <= bt_unwind ? ST_UNWIND : ST_IDLE;
      end
      if (imp_clash) begin
        conflict_q <= 1'b1;
        state_q    <= ST_CONFLICT;
      end
      if (dec_take) begin
        level_q <= level_q + ID_ONE;
      end
      if (push_en) begin
        trail_count_q <= trail_count_q + ID_ONE;
      end
      if (pop_go) begin
        trail_count_q <= trail_count_q - ID_ONE;
      end
      if (unwind_done) begin
        level_q <= bt_target_q;
        state_q <= ST_IDLE;
      end
    end
  end

  // Assignment table: set on push, cleared (value forced to 0) on pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      assigned_q <= '0;
      val_q      <= '0;
    end else begin
      if (push_en) begin
        assigned_q[push_var] <= 1'b1;
        val_q[push_var]      <= push_val;
      end
      if (pop_go) begin
        assigned_q[top_var] <= 1'b0;
        val_q[top_var]      <= 1'b0;
      end
    end
  end

  // Trail storage; contents above trail_count are don't-care so no reset is needed.
  always_ff @(posedge clock) begin
    if (push_en) begin
      trail_var_mem[trail_count_q] <= push_var;
      trail_lvl_mem[trail_count_q] <= push_lvl;
    end
  end

  // Per-clause reads straight off the registered table; val is already 0 when unassigned.
  always_comb begin
    rd_unassign = '0;
    rd_val      = '0;
    for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
      rd_unassign[i] = ~assigned_q[rd_var[i]];
      rd_val[i]      = val_q[rd_var[i]];
    end
  end

`ifdef VAT_STATS_EN
  logic [15:0] imp_count_q;
  logic [15:0] conf_count_q;

  // Saturating statistics counters, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      imp_count_q  <= '0;
      conf_count_q <= '0;
    end else begin
      if (imp_write && (imp_count_q != 16'hFFFF)) begin
        imp_count_q <= imp_count_q + 16'd1;
      end
      if (imp_clash && (conf_count_q != 16'hFFFF)) begin
        conf_count_q <= conf_count_q + 16'd1;
      end
    end
  end

  assign imp_count  = imp_count_q;
  assign conf_count = conf_count_q;
`else
  assign imp_count  = 16'd0;
  assign conf_count = 16'd0;
`endif

endmodule

// File: tb/tb_var_assign_table.sv
// Testbench for var_assign_table: directed vector table, hand-written multi-cycle
// sequences (unwind timing, same-cycle requests, reset during UNWIND/CONFLICT) and a
// randomized run against a behavioural model of the assignment store and trail.
module tb_var_assign_table;

  localparam int OP_IMP = 0;
  localparam int OP_DEC = 1;
  localparam int OP_BT  = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             imp_valid;
  logic [6:0]       imp_var;
  logic             imp_val;
  logic             imp_ready;
  logic             dec_valid;
  logic [6:0]       dec_var;
  logic             dec_val;
  logic             bt_valid;
  logic [6:0]       bt_level;
  logic [4:0][6:0]  rd_var;
  logic [4:0]       rd_unassign;
  logic [4:0]       rd_val;
  logic [6:0]       level;
  logic [6:0]       trail_count;
  logic             conflict;
  logic             busy;
  logic [15:0]      imp_count;
  logic [15:0]      conf_count;

  int tests = 0;
  int fails = 0;

  var_assign_table dut (
    .clock(clock), .reset(reset),
    .imp_valid(imp_valid), .imp_var(imp_var), .imp_val(imp_val), .imp_ready(imp_ready),
    .dec_valid(dec_valid), .dec_var(dec_var), .dec_val(dec_val),
    .bt_valid(bt_valid), .bt_level(bt_level),
    .rd_var(rd_var), .rd_unassign(rd_unassign), .rd_val(rd_val),
    .level(level), .trail_count(trail_count), .conflict(conflict), .busy(busy),
    .imp_count(imp_count), .conf_count(conf_count)
  );

  always #10 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int              op;
    logic [6:0]      v;
    logic            b;
    logic [4:0][6:0] rv;
    int              e_level;
    int              e_trail;
    logic            e_conf;
    logic            e_ready;
    int              e_busy;
    logic [4:0]      e_un;
    logic [4:0]      e_val;
  } vec_t;

  vec_t vecs[$];

  // behavioural model: plain arrays plus a stack of {var, level}
  bit m_asg[128];
  bit m_val[128];
  int q_var[$];
  int q_lvl[$];
  int m_level;
  bit m_conf;
  int m_imp_cnt;
  int m_conf_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_stat(input int c);
`ifdef VAT_STATS_EN
    return (c > 65535) ? 65535 : c;
`else
    return 0;
`endif
  endfunction

  function automatic void add_vec(input int op, input int v, input bit b, input logic [4:0][6:0] rv,
                                  input int el, input int et, input bit ec, input bit er,
                                  input int eb, input logic [4:0] eu, input logic [4:0] ev);
    vec_t t;
    t.op = op; t.v = 7'(v); t.b = b; t.rv = rv;
    t.e_level = el; t.e_trail = et; t.e_conf = ec; t.e_ready = er;
    t.e_busy = eb; t.e_un = eu; t.e_val = ev;
    vecs.push_back(t);
  endfunction

  task automatic clear_inputs();
    imp_valid = 1'b0; imp_var = '0; imp_val = 1'b0;
    dec_valid = 1'b0; dec_var = '0; dec_val = 1'b0;
    bt_valid  = 1'b0; bt_level = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Starts just after a negedge; drives one request cycle, then waits out any unwind.
  task automatic drive_op(input bit b, input logic [6:0] bl, input bit d, input logic [6:0] dv,
                          input bit dval, input bit i, input logic [6:0] iv, input bit ival,
                          output logic ready_seen, output int busy_cycles);
    bt_valid = b; bt_level = bl;
    dec_valid = d; dec_var = dv; dec_val = dval;
    imp_valid = i; imp_var = iv; imp_val = ival;
    #1 ready_seen = imp_ready;
    @(negedge clock);
    clear_inputs();
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 300) begin
      @(negedge clock);
      busy_cycles++;
    end
  endtask

  task automatic check_rd(input string name, input logic [4:0][6:0] rv,
                          input logic [4:0] eu, input logic [4:0] ev);
    rd_var = rv;
    #1;
    chk({name, ".rd_unassign"}, 32'(rd_unassign), 32'(eu));
    chk({name, ".rd_val"}, 32'(rd_val), 32'(ev));
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 128; k++) begin m_asg[k] = 0; m_val[k] = 0; end
    q_var.delete(); q_lvl.delete();
    m_level = 0; m_conf = 0; m_imp_cnt = 0; m_conf_cnt = 0;
  endfunction

  // Applies one request cycle to the model; returns the expected number of busy cycles.
  function automatic int model_step(input bit b, input int bl, input bit d, input int dv,
                                    input bit dval, input bit i, input int iv, input bit ival);
    int pops;
    if (b) begin
      m_conf = 0;
      if (bl < m_level) begin
        pops = 0;
        while (q_var.size() > 0 && q_lvl[q_lvl.size()-1] > bl) begin
          m_asg[q_var[q_var.size()-1]] = 0;
          m_val[q_var[q_var.size()-1]] = 0;
          void'(q_var.pop_back());
          void'(q_lvl.pop_back());
          pops++;
        end
        m_level = bl;
        return pops + 1;
      end
      return 0;
    end
    if (m_conf) return 0;
    if (d) begin
      if (dv != 0 && !m_asg[dv]) begin
        m_level++;
        m_asg[dv] = 1; m_val[dv] = dval;
        q_var.push_back(dv); q_lvl.push_back(m_level);
      end
      return 0;
    end
    if (i && iv != 0) begin
      if (!m_asg[iv]) begin
        m_asg[iv] = 1; m_val[iv] = ival;
        q_var.push_back(iv); q_lvl.push_back(m_level);
        m_imp_cnt++;
      end else if (m_val[iv] != ival) begin
        m_conf = 1;
        m_conf_cnt++;
      end
    end
    return 0;
  endfunction

  initial begin
    logic [4:0][6:0] rv, rv2, rv3, rva;
    logic            rdy;
    int              bc;
    logic [4:0]      eu, ev;
    string           nm;

    rd_var = '0;
    clear_inputs();
    rv  = {7'd0, 7'd0, 7'd0, 7'd5, 7'd3};
    rv2 = {7'd0, 7'd0, 7'd10, 7'd9, 7'd3};
    rv3 = {7'd0, 7'd0, 7'd0, 7'd0, 7'd12};

    //        op      v   b  rd   lvl trl cf rdy bsy  unassign   val
    add_vec(OP_DEC,   3, 1, rv,   1, 1, 0, 0, 0, 5'b11110, 5'b00001);
    add_vec(OP_IMP,   5, 0, rv,   1, 2, 0, 1, 0, 5'b11100, 5'b00001);
    add_vec(OP_IMP,   5, 0, rv,   1, 2, 0, 1, 0, 5'b11100, 5'b00001);
    add_vec(OP_IMP,   0, 1, rv,   1, 2, 0, 1, 0, 5'b11100, 5'b00001);
    add_vec(OP_DEC,   5, 1, rv,   1, 2, 0, 0, 0, 5'b11100, 5'b00001);
    add_vec(OP_DEC,   0, 1, rv,   1, 2, 0, 0, 0, 5'b11100, 5'b00001);
    add_vec(OP_IMP,   5, 1, rv,   1, 2, 1, 1, 0, 5'b11100, 5'b00001);
    add_vec(OP_IMP,   7, 1, rv,   1, 2, 1, 0, 0, 5'b11100, 5'b00001);
    add_vec(OP_DEC,   7, 1, rv,   1, 2, 1, 0, 0, 5'b11100, 5'b00001);
    add_vec(OP_BT,    1, 0, rv,   1, 2, 0, 0, 0, 5'b11100, 5'b00001);
    add_vec(OP_DEC,   9, 0, rv2,  2, 3, 0, 0, 0, 5'b11100, 5'b00001);
    add_vec(OP_IMP,  10, 1, rv2,  2, 4, 0, 1, 0, 5'b11000, 5'b00101);
    add_vec(OP_IMP,   9, 1, rv2,  2, 4, 1, 1, 0, 5'b11000, 5'b00101);
    add_vec(OP_BT,    1, 0, rv2,  1, 2, 0, 0, 3, 5'b11110, 5'b00001);
    add_vec(OP_BT,    0, 0, rv,   0, 0, 0, 0, 3, 5'b11111, 5'b00000);
    add_vec(OP_IMP,  12, 1, rv3,  0, 1, 0, 1, 0, 5'b11110, 5'b00001);
    add_vec(OP_DEC,  13, 1, rv3,  1, 2, 0, 0, 0, 5'b11110, 5'b00001);
    add_vec(OP_BT,    0, 0, rv3,  0, 1, 0, 0, 2, 5'b11110, 5'b00001);

    // ---- reset state ----
    do_reset();
    chk("reset.level", 32'(level), 32'd0);
    chk("reset.trail_count", 32'(trail_count), 32'd0);
    chk("reset.conflict", 32'(conflict), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.imp_count", 32'(imp_count), 32'd0);
    chk("reset.conf_count", 32'(conf_count), 32'd0);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 5; j++) rva[j] = 7'($urandom_range(0, 127));
      check_rd($sformatf("reset.rd%0d", k), rva, 5'b11111, 5'b00000);
    end

    // ---- directed vector table ----
    foreach (vecs[k]) begin
      nm = $sformatf("vec%0d", k);
      drive_op(vecs[k].op == OP_BT, vecs[k].v, vecs[k].op == OP_DEC, vecs[k].v, vecs[k].b,
               vecs[k].op == OP_IMP, vecs[k].v, vecs[k].b, rdy, bc);
      chk({nm, ".imp_ready"}, 32'(rdy), 32'(vecs[k].e_ready));
      chk({nm, ".busy_cycles"}, 32'(bc), 32'(vecs[k].e_busy));
      chk({nm, ".level"}, 32'(level), 32'(vecs[k].e_level));
      chk({nm, ".trail_count"}, 32'(trail_count), 32'(vecs[k].e_trail));
      chk({nm, ".conflict"}, 32'(conflict), 32'(vecs[k].e_conf));
      check_rd(nm, vecs[k].rv, vecs[k].e_un, vecs[k].e_val);
    end
    // three implication writes (vars 5, 10, 12) and two conflicts in the table
    chk("table.imp_count", 32'(imp_count), 32'(exp_stat(3)));
    chk("table.conf_count", 32'(conf_count), 32'(exp_stat(2)));

    // ---- levels 1..3, two entries each, backtrack to 1 with requests during UNWIND ----
    do_reset();
    drive_op(0, 0, 1, 7'd1, 1, 0, 0, 0, rdy, bc);
    drive_op(0, 0, 0, 0, 0, 1, 7'd2, 0, rdy, bc);
    drive_op(0, 0, 1, 7'd3, 1, 0, 0, 0, rdy, bc);
    drive_op(0, 0, 0, 0, 0, 1, 7'd4, 1, rdy, bc);
    drive_op(0, 0, 1, 7'd5, 0, 0, 0, 0, rdy, bc);
    drive_op(0, 0, 0, 0, 0, 1, 7'd6, 1, rdy, bc);
    chk("seqA.pre_level", 32'(level), 32'd3);
    chk("seqA.pre_trail", 32'(trail_count), 32'd6);
    bt_valid = 1'b1; bt_level = 7'd1;
    @(negedge clock);
    bt_valid = 1'b1; bt_level = 7'd0;
    dec_valid = 1'b1; dec_var = 7'd20; dec_val = 1'b1;
    imp_valid = 1'b1; imp_var = 7'd21; imp_val = 1'b1;
    #1;
    chk("seqA.busy_now", 32'(busy), 32'd1);
    chk("seqA.imp_ready_unwind", 32'(imp_ready), 32'd0);
    bc = 0;
    @(negedge clock);
    bc++;
    clear_inputs();
    while (busy === 1'b1 && bc < 300) begin
      @(negedge clock);
      bc++;
    end
    chk("seqA.busy_cycles", 32'(bc), 32'd5);
    chk("seqA.level", 32'(level), 32'd1);
    chk("seqA.trail", 32'(trail_count), 32'd2);
    chk("seqA.conflict", 32'(conflict), 32'd0);
    check_rd("seqA", {7'd21, 7'd20, 7'd3, 7'd2, 7'd1}, 5'b11100, 5'b00001);

    // ---- same-cycle backtrack, decision and implication: only backtrack acts ----
    drive_op(1, 7'd0, 1, 7'd22, 1, 1, 7'd23, 1, rdy, bc);
    chk("seqB.imp_ready", 32'(rdy), 32'd0);
    chk("seqB.busy_cycles", 32'(bc), 32'd3);
    chk("seqB.level", 32'(level), 32'd0);
    chk("seqB.trail", 32'(trail_count), 32'd0);
    check_rd("seqB", {7'd23, 7'd22, 7'd0, 7'd2, 7'd1}, 5'b11111, 5'b00000);

    // ---- reset asserted mid-UNWIND ----
    drive_op(0, 0, 1, 7'd1, 1, 0, 0, 0, rdy, bc);
    drive_op(0, 0, 0, 0, 0, 1, 7'd2, 1, rdy, bc);
    drive_op(0, 0, 1, 7'd3, 0, 0, 0, 0, rdy, bc);
    bt_valid = 1'b1; bt_level = 7'd0;
    @(negedge clock);
    clear_inputs();
    chk("seqC.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("seqC.busy", 32'(busy), 32'd0);
    chk("seqC.level", 32'(level), 32'd0);
    chk("seqC.trail", 32'(trail_count), 32'd0);
    check_rd("seqC", {7'd0, 7'd0, 7'd3, 7'd2, 7'd1}, 5'b11111, 5'b00000);

    // ---- reset asserted mid-CONFLICT ----
    drive_op(0, 0, 0, 0, 0, 1, 7'd8, 1, rdy, bc);
    drive_op(0, 0, 0, 0, 0, 1, 7'd8, 0, rdy, bc);
    chk("seqD.conflict_set", 32'(conflict), 32'd1);
    chk("seqD.conf_count", 32'(conf_count), 32'(exp_stat(1)));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("seqD.conflict", 32'(conflict), 32'd0);
    chk("seqD.trail", 32'(trail_count), 32'd0);
    chk("seqD.imp_count", 32'(imp_count), 32'd0);
    chk("seqD.conf_count_rst", 32'(conf_count), 32'd0);
    #1 chk("seqD.imp_ready", 32'(imp_ready), 32'd1);

    // ---- randomized run against the model ----
    do_reset();
    model_reset();
    for (int n = 0; n < 300; n++) begin
      bit   b, d, i, dval, ival, eready;
      int   bl, dv, iv, ebusy;
      b    = ($urandom_range(0, 99) < 15);
      d    = ($urandom_range(0, 99) < 25);
      i    = ($urandom_range(0, 99) < 70);
      bl   = $urandom_range(0, m_level + 1);
      dv   = $urandom_range(0, 15);
      iv   = $urandom_range(0, 15);
      dval = 1'($urandom_range(0, 1));
      ival = 1'($urandom_range(0, 1));
      eready = !m_conf && !b && !d;
      ebusy  = model_step(b, bl, d, dv, dval, i, iv, ival);
      drive_op(b, 7'(bl), d, 7'(dv), dval, i, 7'(iv), ival, rdy, bc);
      nm = $sformatf("rnd%0d", n);
      chk({nm, ".imp_ready"}, 32'(rdy), 32'(eready));
      chk({nm, ".busy_cycles"}, 32'(bc), 32'(ebusy));
      chk({nm, ".level"}, 32'(level), 32'(m_level));
      chk({nm, ".trail"}, 32'(trail_count), 32'(q_var.size()));
      chk({nm, ".conflict"}, 32'(conflict), 32'(m_conf));
      chk({nm, ".imp_count"}, 32'(imp_count), 32'(exp_stat(m_imp_cnt)));
      chk({nm, ".conf_count"}, 32'(conf_count), 32'(exp_stat(m_conf_cnt)));
      for (int j = 0; j < 5; j++) begin
        rva[j] = 7'($urandom_range(0, 15));
        eu[j]  = !m_asg[rva[j]];
        ev[j]  = m_asg[rva[j]] ? m_val[rva[j]] : 1'b0;
      end
      check_rd(nm, rva, eu, ev);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
